// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, data/valid strobe back.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over the imem handshake, applies
// control_unit advance/redirect commands.
//
// state | meaning
// IDLE  | post-reset, start fetching next cycle
// REQ   | request issued for PC
// WAIT  | waiting for imem_valid (timeout counted here)
// READY | IR holds the word at PC, waiting for a command
// HALT  | misaligned redirect or memory timeout, only reset exits
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                       fetch_clk,
  input  logic                       fetch_rst_n,
  input  logic                       ic_count,
  input  logic                       ic_dir,
  input  logic                       ic_wr_en,
  input  logic [31:0]                branch_target,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instr_out,
  output logic                       instr_valid,
  output logic [31:0]                pc_out,
  output logic                       fetch_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] READY = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]    state;
  logic [31:0]   pc;
  logic [31:0]   ir;
  logic          flush;
  logic [CW-1:0] to_cnt;
  logic          misaligned;

  assign misaligned     = (branch_target[1:0] != 2'b00);
  assign imem.imem_req  = (state == REQ) || (state == WAIT);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == READY);
  assign instr_out      = ir;
  assign pc_out         = pc;

  always_ff @(posedge fetch_clk) begin
    if (!fetch_rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= NOP;
      flush     <= 1'b0;
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= REQ;
          to_cnt <= '0;
        end
        REQ: begin
          to_cnt <= '0;
          if (ic_wr_en && misaligned) begin
            fetch_err <= 1'b1;
            state     <= HALT;
          end else begin
            // memory may already have taken the old address; drop its reply
            if (ic_wr_en) begin
              pc    <= branch_target;
              flush <= 1'b1;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (ic_wr_en && misaligned) begin
            fetch_err <= 1'b1;
            state     <= HALT;
          end else if (imem.imem_valid) begin
            if (ic_wr_en) pc <= branch_target;
            if (flush || ic_wr_en) begin
              flush <= 1'b0;
              state <= REQ;
            end else begin
              ir    <= imem.imem_rdata;
              state <= READY;
            end
          end else if (to_cnt == TO_LAST) begin
            fetch_err <= 1'b1;
            state     <= HALT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (ic_wr_en) begin
              pc    <= branch_target;
              flush <= 1'b1;
            end
          end
        end
        READY: begin
          if (ic_wr_en) begin
            if (misaligned) begin
              fetch_err <= 1'b1;
              state     <= HALT;
            end else begin
              pc    <= branch_target;
              state <= REQ;
            end
          end else if (ic_count) begin
            pc    <= ic_dir ? pc - 32'd4 : pc + 32'd4;
            state <= REQ;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
